// File: rtl/thread_scheduler_pkg.sv
// Shared types and sizing for the barrel thread scheduler.
// Latency: n/a (types, constants and a decode helper only).
// Backpressure: n/a.
package sched_pkg;

  localparam int NUM_THREADS = 16;  // must equal register-file thread depth
  localparam int TID_W       = 5;   // matches register-file thread_read/thread_write
  localparam int PIPE_DEPTH  = 4;   // unstalled cycles from issue to writeback, >= 1

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic             valid;
    logic [TID_W-1:0] tid;
  } pipe_entry_t;

  typedef logic [NUM_THREADS-1:0] thread_mask_t;

  // One-hot decode of a thread index; indices >= NUM_THREADS decode to zero.
  function automatic thread_mask_t tid_onehot(input logic [TID_W-1:0] tid);
    thread_mask_t m;
    m = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (tid == TID_W'(i)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/thread_scheduler_if.sv
// Control/status bundle between a block launcher and the thread scheduler.
// Latency: n/a (wires only).
// Backpressure: stall_i freezes the scheduler; no other flow control.
// slave  : scheduler side (launch/count/bidx/stall/halt in; issue/wb/bidx/busy/done out)
// master : launcher / pipeline side, mirror of slave
interface thread_scheduler_if;
  import sched_pkg::*;

  logic             launch_i;
  logic [TID_W-1:0] thread_count_i;
  logic [31:0]      bidx_i;
  logic             stall_i;
  logic             halt_i;
  logic             issue_valid_o;
  logic [TID_W-1:0] thread_read_o;
  logic             wb_valid_o;
  logic [TID_W-1:0] thread_write_o;
  logic [31:0]      bidx_o;
  logic             busy_o;
  logic             done_o;

  modport slave (
    input  launch_i, thread_count_i, bidx_i, stall_i, halt_i,
    output issue_valid_o, thread_read_o, wb_valid_o, thread_write_o,
           bidx_o, busy_o, done_o
  );

  modport master (
    output launch_i, thread_count_i, bidx_i, stall_i, halt_i,
    input  issue_valid_o, thread_read_o, wb_valid_o, thread_write_o,
           bidx_o, busy_o, done_o
  );

endinterface

// File: rtl/thread_scheduler_rr_arbiter.sv
// Round-robin grant over the thread request mask, starting strictly after ptr.
// Latency: combinational.
// Backpressure: none; gnt_valid=0 when no request is set.
// Ports: req (one bit per thread), ptr (last granted index) -> gnt_valid, gnt_idx
//        (gnt_idx is 0 when nothing is granted).
module rr_arbiter
  import sched_pkg::*;
(
  input  thread_mask_t     req,
  input  logic [TID_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [TID_W-1:0] gnt_idx
);

  localparam int IDX_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester after ptr
  // is the last one written and therefore wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = NUM_THREADS; k >= 1; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_THREADS);
      if (req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = TID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/thread_scheduler.sv
// Barrel thread scheduler: issues one ready thread per cycle and tracks each op to writeback.
// Latency: issue visible in the cycle after launch; writeback exactly PIPE_DEPTH unstalled cycles after issue.
// Backpressure: stall_i freezes issue and the tracking pipe; a thread has at most one op in flight.
// Ports: clk, rst (async, active-high); bus (slave modport):
//   launch_i/thread_count_i/bidx_i start a block from IDLE; stall_i, halt_i from the pipeline;
//   issue_valid_o/thread_read_o drive regfile read select, wb_valid_o/thread_write_o the write
//   select, bidx_o the regfile bIdx; busy_o in RUN/DRAIN, done_o one cycle in DONE.
module thread_scheduler
  import sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  thread_scheduler_if.slave   bus
);

  sched_state_t                   state_q, state_d;
  thread_mask_t                   active_q, active_d;
  thread_mask_t                   halted_q, halted_d;
  thread_mask_t                   inflight_q, inflight_d;
  logic [TID_W-1:0]               ptr_q, ptr_d;
  logic [TID_W-1:0]               thread_read_q, thread_read_d;
  logic [31:0]                    bidx_q, bidx_d;
  pipe_entry_t [PIPE_DEPTH-1:0]   pipe_q, pipe_d;

  thread_mask_t                   runnable;
  thread_mask_t                   ready;
  thread_mask_t                   launch_mask;
  logic [TID_W-1:0]               count_sat;
  logic                           gnt_valid;
  logic [TID_W-1:0]               gnt_idx;
  logic                           issue_vld;
  logic                           wb_vld;
  logic                           pipe_busy;
  pipe_entry_t                    tail;

  // A thread is eligible only while nothing of its own is in flight, which keeps
  // same-thread RAW hazards out of the pipe. A thread retiring this cycle is still
  // marked in flight here, so it reissues one cycle later at the earliest.
  always_comb begin
    runnable = active_q & ~halted_q;
    ready    = runnable & ~inflight_q;
  end

  rr_arbiter u_arb (
    .req       (ready),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    tail      = pipe_q[PIPE_DEPTH-1];
    issue_vld = (state_q == S_RUN) && !bus.stall_i && gnt_valid;
    wb_vld    = tail.valid && !bus.stall_i;

    pipe_busy = 1'b0;
    for (int s = 0; s < PIPE_DEPTH; s++) begin
      pipe_busy = pipe_busy | pipe_q[s].valid;
    end

    count_sat = (bus.thread_count_i > TID_W'(NUM_THREADS)) ? TID_W'(NUM_THREADS)
                                                           : bus.thread_count_i;
    launch_mask = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      launch_mask[i] = (TID_W'(i) < count_sat);
    end
  end

  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    halted_d      = halted_q;
    inflight_d    = inflight_q;
    ptr_d         = ptr_q;
    thread_read_d = thread_read_q;
    bidx_d        = bidx_q;
    pipe_d        = pipe_q;

    // Retire and issue always involve different threads: the granted thread is
    // not in flight, while the retiring one is.
    if (wb_vld) begin
      inflight_d = inflight_d & ~tid_onehot(tail.tid);
      if (bus.halt_i) halted_d = halted_d | tid_onehot(tail.tid);
    end
    if (issue_vld) begin
      inflight_d    = inflight_d | tid_onehot(gnt_idx);
      ptr_d         = gnt_idx;
      thread_read_d = gnt_idx;
    end

    if (!bus.stall_i) begin
      pipe_d[0].valid = issue_vld;
      pipe_d[0].tid   = issue_vld ? gnt_idx : '0;
      for (int s = 1; s < PIPE_DEPTH; s++) begin
        pipe_d[s] = pipe_q[s-1];
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.launch_i) begin
          state_d    = S_RUN;
          active_d   = launch_mask;
          halted_d   = '0;
          inflight_d = '0;
          bidx_d     = bus.bidx_i;
        end
      end
      S_RUN: begin
        if (runnable == '0) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!bus.stall_i && !pipe_busy) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      active_q      <= '0;
      halted_q      <= '0;
      inflight_q    <= '0;
      ptr_q         <= TID_W'(NUM_THREADS - 1);
      thread_read_q <= '0;
      bidx_q        <= '0;
      pipe_q        <= '0;
    end else begin
      state_q       <= state_d;
      active_q      <= active_d;
      halted_q      <= halted_d;
      inflight_q    <= inflight_d;
      ptr_q         <= ptr_d;
      thread_read_q <= thread_read_d;
      bidx_q        <= bidx_d;
      pipe_q        <= pipe_d;
    end
  end

  // thread_read_o holds the last granted index when nothing issues.
  assign bus.issue_valid_o  = issue_vld;
  assign bus.thread_read_o  = issue_vld ? gnt_idx : thread_read_q;
  assign bus.wb_valid_o     = wb_vld;
  assign bus.thread_write_o = tail.tid;
  assign bus.bidx_o         = bidx_q;
  assign bus.busy_o         = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done_o         = (state_q == S_DONE);

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed bench for thread_scheduler: issue/writeback traces are logged per cycle
// relative to the launch edge and compared against hand-derived schedules.
// Latency/backpressure: n/a (bench).
module tb_thread_scheduler;
  import sched_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  thread_scheduler_if bus();
  thread_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lc = 0;
  int busy_last = -1;
  int iss_c[$], iss_t[$], wb_c[$], wb_t[$], done_c[$];
  logic [45:0] obs;

  always @(posedge clk) cyc <= cyc + 1;

  // Cycle numbers are relative to the cycle in which launch_i was driven.
  always @(negedge clk) begin
    if (bus.issue_valid_o) begin iss_c.push_back(cyc - lc); iss_t.push_back(int'(bus.thread_read_o)); end
    if (bus.wb_valid_o)    begin wb_c.push_back(cyc - lc);  wb_t.push_back(int'(bus.thread_write_o)); end
    if (bus.done_o)        done_c.push_back(cyc - lc);
    if (bus.busy_o)        busy_last = cyc - lc;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic launch_and_run(input logic [TID_W-1:0] cnt, input logic [31:0] bidx, input int n,
                                input logic [63:0] stall_m, input logic [63:0] halt_m, input int relaunch_r);
    @(posedge clk); #1;
    bus.launch_i = 1'b1; bus.thread_count_i = cnt; bus.bidx_i = bidx;
    lc = cyc; busy_last = -1;
    iss_c.delete(); iss_t.delete(); wb_c.delete(); wb_t.delete(); done_c.delete();
    for (int r = 1; r <= n; r++) begin
      @(posedge clk); #1;
      bus.launch_i = (r == relaunch_r);
      if (r == relaunch_r) begin bus.thread_count_i = 5'd16; bus.bidx_i = 32'hBAD0_0BAD; end
      bus.stall_i = stall_m[6'(r)];
      bus.halt_i  = halt_m[6'(r)];
    end
    @(negedge clk); #1;
    bus.launch_i = 1'b0; bus.stall_i = 1'b0; bus.halt_i = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #2;
    obs = {bus.issue_valid_o, bus.thread_read_o, bus.wb_valid_o, bus.thread_write_o, bus.bidx_o, bus.busy_o, bus.done_o};
    tests++; if (obs !== 46'd0) begin fails++; $display("FAIL reset_in outputs got %h want 0", obs); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    obs = {bus.issue_valid_o, bus.thread_read_o, bus.wb_valid_o, bus.thread_write_o, bus.bidx_o, bus.busy_o, bus.done_o};
    tests++; if (obs !== 46'd0) begin fails++; $display("FAIL reset_idle outputs got %h want 0", obs); end
  endtask

  // count=16 and an oversized count=31 (saturates to 16) give the same rotation.
  task automatic test_full_rotation();
    int cnts[2] = '{16, 31};
    for (int c = 0; c < 2; c++) begin
      do_reset();
      launch_and_run(5'(cnts[c]), 32'hA5A5_0000 + 32'(cnts[c]), 20, '0, '0, -1);
      tests++;
      if (iss_c.size() != 20) begin fails++; $display("FAIL rot%0d issue_count got %0d want 20", cnts[c], iss_c.size()); end
      else for (int k = 0; k < 20; k++) begin
        tests++;
        if (iss_c[k] !== k + 1 || iss_t[k] !== k % 16) begin
          fails++; $display("FAIL rot%0d issue[%0d] got cyc %0d tid %0d want cyc %0d tid %0d", cnts[c], k, iss_c[k], iss_t[k], k + 1, k % 16);
        end
      end
      tests++;
      if (wb_c.size() != 16) begin fails++; $display("FAIL rot%0d wb_count got %0d want 16", cnts[c], wb_c.size()); end
      else for (int k = 0; k < 16; k++) begin
        tests++;
        if (wb_c[k] !== k + 5 || wb_t[k] !== k) begin
          fails++; $display("FAIL rot%0d wb[%0d] got cyc %0d tid %0d want cyc %0d tid %0d", cnts[c], k, wb_c[k], wb_t[k], k + 5, k);
        end
      end
      tests++;
      if (bus.bidx_o !== 32'hA5A5_0000 + 32'(cnts[c])) begin
        fails++; $display("FAIL rot%0d bidx got %h want %h", cnts[c], bus.bidx_o, 32'hA5A5_0000 + 32'(cnts[c]));
      end
    end
  endtask

  task automatic test_single_thread_halt();
    do_reset();
    launch_and_run(5'd1, 32'h0000_0002, 15, '0, 64'd1 << 10, -1);
    tests++;
    if (iss_c.size() != 2 || iss_c[0] !== 1 || iss_c[1] !== 6 || iss_t[0] !== 0 || iss_t[1] !== 0) begin
      fails++; $display("FAIL single_issue got n=%0d first=%0d want n=2 cycles 1,6 tid 0", iss_c.size(), (iss_c.size() > 0) ? iss_c[0] : -1);
    end
    tests++;
    if (wb_c.size() != 2 || wb_c[0] !== 5 || wb_c[1] !== 10 || wb_t[0] !== 0 || wb_t[1] !== 0) begin
      fails++; $display("FAIL single_wb got n=%0d want n=2 cycles 5,10 tid 0", wb_c.size());
    end
    tests++;
    if (done_c.size() != 1 || done_c[0] !== 13) begin
      fails++; $display("FAIL single_done got n=%0d first=%0d want n=1 cycle 13", done_c.size(), (done_c.size() > 0) ? done_c[0] : -1);
    end
    tests++;
    if (busy_last !== 12) begin fails++; $display("FAIL single_busy_fall last busy cycle %0d want 12", busy_last); end
  endtask

  task automatic test_stall();
    int e_ic[11] = '{1, 2, 3, 4, 6, 10, 11, 12, 14, 15, 16};
    int e_it[11] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
    int e_wc[8]  = '{5, 6, 10, 11, 13, 14, 15, 16};
    int e_wt[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset();
    launch_and_run(5'd4, 32'h0000_0003, 16, 64'h380, '0, -1);
    tests++;
    if (iss_c.size() != 11) begin fails++; $display("FAIL stall issue_count got %0d want 11", iss_c.size()); end
    else for (int k = 0; k < 11; k++) begin
      tests++;
      if (iss_c[k] !== e_ic[k] || iss_t[k] !== e_it[k]) begin
        fails++; $display("FAIL stall issue[%0d] got cyc %0d tid %0d want cyc %0d tid %0d", k, iss_c[k], iss_t[k], e_ic[k], e_it[k]);
      end
    end
    tests++;
    if (wb_c.size() != 8) begin fails++; $display("FAIL stall wb_count got %0d want 8", wb_c.size()); end
    else for (int k = 0; k < 8; k++) begin
      tests++;
      if (wb_c[k] !== e_wc[k] || wb_t[k] !== e_wt[k]) begin
        fails++; $display("FAIL stall wb[%0d] got cyc %0d tid %0d want cyc %0d tid %0d", k, wb_c[k], wb_t[k], e_wc[k], e_wt[k]);
      end
    end
  endtask

  // Real halt of tid 2 at cycle 7; halts at 9 and 12 arrive without a writeback.
  task automatic test_halt_rotation();
    int e_ic[12] = '{1, 2, 3, 4, 6, 7, 9, 11, 12, 14, 16, 17};
    int e_it[12] = '{0, 1, 2, 3, 0, 1, 3, 0, 1, 3, 0, 1};
    int e_wc[9]  = '{5, 6, 7, 8, 10, 11, 13, 15, 16};
    int e_wt[9]  = '{0, 1, 2, 3, 0, 1, 3, 0, 1};
    do_reset();
    launch_and_run(5'd4, 32'h0000_0004, 17, '0, (64'd1 << 7) | (64'd1 << 9) | (64'd1 << 12), -1);
    tests++;
    if (iss_c.size() != 12) begin fails++; $display("FAIL halt issue_count got %0d want 12", iss_c.size()); end
    else for (int k = 0; k < 12; k++) begin
      tests++;
      if (iss_c[k] !== e_ic[k] || iss_t[k] !== e_it[k]) begin
        fails++; $display("FAIL halt issue[%0d] got cyc %0d tid %0d want cyc %0d tid %0d", k, iss_c[k], iss_t[k], e_ic[k], e_it[k]);
      end
    end
    tests++;
    if (wb_c.size() != 9) begin fails++; $display("FAIL halt wb_count got %0d want 9", wb_c.size()); end
    else for (int k = 0; k < 9; k++) begin
      tests++;
      if (wb_c[k] !== e_wc[k] || wb_t[k] !== e_wt[k]) begin
        fails++; $display("FAIL halt wb[%0d] got cyc %0d tid %0d want cyc %0d tid %0d", k, wb_c[k], wb_t[k], e_wc[k], e_wt[k]);
      end
    end
  endtask

  task automatic test_launch_ignored_and_empty();
    int e_ic[4] = '{1, 2, 6, 7};
    int e_it[4] = '{0, 1, 0, 1};
    do_reset();
    launch_and_run(5'd2, 32'h1111_2222, 8, '0, '0, 3);
    tests++;
    if (iss_c.size() != 4) begin fails++; $display("FAIL relaunch issue_count got %0d want 4", iss_c.size()); end
    else for (int k = 0; k < 4; k++) begin
      tests++;
      if (iss_c[k] !== e_ic[k] || iss_t[k] !== e_it[k]) begin
        fails++; $display("FAIL relaunch issue[%0d] got cyc %0d tid %0d want cyc %0d tid %0d", k, iss_c[k], iss_t[k], e_ic[k], e_it[k]);
      end
    end
    tests++;
    if (bus.bidx_o !== 32'h1111_2222) begin fails++; $display("FAIL relaunch bidx got %h want 11112222", bus.bidx_o); end

    do_reset();
    launch_and_run(5'd0, 32'h3333_4444, 5, '0, '0, -1);
    tests++;
    if (done_c.size() != 1 || done_c[0] !== 3) begin
      fails++; $display("FAIL empty_done got n=%0d first=%0d want n=1 cycle 3", done_c.size(), (done_c.size() > 0) ? done_c[0] : -1);
    end
    tests++;
    if (iss_c.size() != 0 || wb_c.size() != 0) begin
      fails++; $display("FAIL empty_activity got issues %0d wbs %0d want 0 0", iss_c.size(), wb_c.size());
    end
    tests++;
    if (busy_last !== 2) begin fails++; $display("FAIL empty_busy last busy cycle %0d want 2", busy_last); end
    tests++;
    if (bus.bidx_o !== 32'h3333_4444) begin fails++; $display("FAIL empty_bidx_hold got %h want 33334444", bus.bidx_o); end
  endtask

  task automatic test_async_reset();
    do_reset();
    launch_and_run(5'd4, 32'h0000_0055, 3, '0, '0, -1);
    tests++;
    if (bus.issue_valid_o !== 1'b1 || bus.thread_read_o !== 5'd2 || bus.busy_o !== 1'b1) begin
      fails++; $display("FAIL areset_pre got vld %b tid %0d busy %b want 1 2 1", bus.issue_valid_o, bus.thread_read_o, bus.busy_o);
    end
    rst = 1'b1;
    #1;
    obs = {bus.issue_valid_o, bus.thread_read_o, bus.wb_valid_o, bus.thread_write_o, bus.bidx_o, bus.busy_o, bus.done_o};
    tests++; if (obs !== 46'd0) begin fails++; $display("FAIL areset_outputs got %h want 0", obs); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    tests++;
    if (done_c.size() != 0 || bus.busy_o !== 1'b0) begin
      fails++; $display("FAIL areset_no_done got done pulses %0d busy %b want 0 0", done_c.size(), bus.busy_o);
    end
    launch_and_run(5'd2, 32'h0000_0066, 3, '0, '0, -1);
    tests++;
    if (iss_c.size() != 2 || iss_c[0] !== 1 || iss_t[0] !== 0 || iss_c[1] !== 2 || iss_t[1] !== 1) begin
      fails++; $display("FAIL areset_relaunch got n=%0d first tid %0d want n=2 tids 0,1 at cycles 1,2", iss_c.size(), (iss_t.size() > 0) ? iss_t[0] : -1);
    end
  endtask

  initial begin
    bus.launch_i = 1'b0;
    bus.thread_count_i = '0;
    bus.bidx_i = '0;
    bus.stall_i = 1'b0;
    bus.halt_i = 1'b0;
    test_reset();
    test_full_rotation();
    test_single_thread_halt();
    test_stall();
    test_halt_rotation();
    test_launch_ignored_and_empty();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
